router_fifo: RTL and testbench
==============================

# router_fifo

Per-port output buffer of the router. Stores bytes driven by the router register stage (the header/payload/parity stream qualified by `lfd_state`) and releases them to the output-port reader. Each stored word carries a header marker so the read side tracks packet boundaries. Three instances sit between the register stage and the three output ports.

## Interface

Parameters:
- `DEPTH`, 16, number of storage words; power of two, ≥ 2.
- `WIDTH`, 8, data byte width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all state immediately.
- `soft_reset`  in  1  synchronous clear for a timed-out port; active-high.
- `write_enb`  in  1  write request from the router FSM/synchroniser.
- `read_enb`  in  1  read request from the output-port reader.
- `lfd_state`  in  1  current write is the packet header; stored as marker bit.
- `data_in`  in  WIDTH  byte from the register stage `dout`.
- `data_out`  out  WIDTH  registered read data.
- `full`  out  1  no free words.
- `empty`  out  1  no stored words.

## Operation

- Storage: DEPTH words of WIDTH+1 bits; bit WIDTH holds `lfd_state` sampled at write.
- Pointers: `wr_ptr` and `rd_ptr`, each log2(DEPTH)+1 bits. Low bits index the storage; the MSB is the wrap flag. Increment modulo 2·DEPTH.
- `empty` = pointers equal. `full` = low bits equal and MSBs differ. Both are combinational from the pointers.
- Write fires when `write_enb && !full`. It stores {`lfd_state`, `data_in`} at `wr_ptr` and increments `wr_ptr`. A write while full is dropped with no state change.
- Read fires when `read_enb && !empty`. It increments `rd_ptr`. A read while empty is ignored.
- Packet counter `count` (6 bits):
  - On a read of a header-marked word: `count` ← `data[7:2] + 1`, which is the payload length plus the parity byte.
  - On a read of a non-header word: `count` ← `count − 1`, saturating at 0.
- `data_out` update rules:
  - On a fired read: `data_out` ← stored byte.
  - No read and `count == 0`: `data_out` ← 0.
  - No read and `count != 0`: hold.
- Simultaneous read and write: both fire if individually legal. Legality is judged on pre-edge `full`/`empty`, so a write at full is dropped even when a read fires in the same cycle.
- `soft_reset`:
  - Clears both pointers, `count` and `data_out` on the next edge.
  - Overrides any read or write in the same cycle.
  - Storage contents are not cleared.
- `rst` low: same clear as `soft_reset` but asynchronous; outputs change without waiting for a clock edge.

## Timing

- Reset values: `data_out` = 0, `full` = 0, `empty` = 1, `count` = 0, both pointers = 0.
- Read latency: 1 cycle. `data_out` is valid in the cycle after the edge on which the read fired.
- `full` and `empty` reflect a write or read in the cycle after its edge.
- Soft reset: `empty` = 1 and `data_out` = 0 in the cycle after the `soft_reset` edge.
- Reset release: first write is accepted on the first rising edge with `rst` high.

## Structure

- Shared package `router_pkg`:
  - `ROUTER_DATA_WIDTH` = 8.
  - `ROUTER_FIFO_DEPTH` = 16.
  - Header length field bounds: `HDR_LEN_MSB` = 7, `HDR_LEN_LSB` = 2.
- Sub-module `router_fifo_mem`: synchronous-write, registered-read dual-port array of DEPTH × (WIDTH+1). Pointer, flag and counter logic stay in `router_fifo`.

## Test plan

- Packet pass-through:
  - Stimulus: write 0x0D with `lfd_state`=1, then 0x07, 0x08, 0x01, parity 0x02; then read 5 times back-to-back.
  - Response: `data_out` = 0x0D, 07, 08, 01, 02 on consecutive cycles; `count` = 4, 3, 2, 1, 0; `data_out` = 0 on the next idle cycle; `empty` = 1.
- Full boundary:
  - Stimulus: 17 writes of 0x00..0x10; then a read and a write in the same cycle.
  - Response: `full` = 1 after the 16th write; 0x10 is dropped; same-cycle read and write at full: read returns 0x00, write dropped, `full` → 0.
- Wrap-around:
  - Stimulus: write and read 10 bytes, then write and read 10 more bytes 0xA0..0xA9.
  - Response: 0xA0..0xA9 read back in order; `full` never asserts; `empty` = 1 at end.
- Read while empty / write when idle:
  - Stimulus: `read_enb`=1 with the FIFO empty; same cycle, write 0x55.
  - Response: no read fires; `data_out` = 0; `empty` = 0 next cycle; 0x55 returned by the following read.
- Soft reset mid-packet:
  - Stimulus: header 0x0D plus 2 payload bytes written; 1 read; then `soft_reset` together with `write_enb`.
  - Response: next cycle `empty` = 1, `data_out` = 0, `count` = 0; the write is dropped.
- Async reset:
  - Stimulus: drop `rst` mid-cycle with 3 words stored.
  - Response: `empty` = 1, `full` = 0 and `data_out` = 0 before the next clock edge.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router constants, packet-counter type and header length helper.
package router_pkg;

  localparam int ROUTER_DATA_WIDTH = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;

  // Header byte layout: payload length lives in bits [7:2].
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int COUNT_W     = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef logic [COUNT_W-1:0] count_t;

  // Bytes still to come after a header: payload length plus the parity byte.
  function automatic count_t hdr_to_count(input count_t len);
    return len + count_t'(1);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// DEPTH x (WIDTH+1) storage: synchronous write, combinational peek, registered read byte.
module router_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH:0]   i_wr_data,
  input  logic             i_rd_en,
  input  logic             i_rd_clr,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH:0]   o_peek,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // NOTE: the array has no reset; only the pointers decide what is readable, so stale words are harmless.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_peek = r_mem[i_rd_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_rd_data <= '0;
    else if (i_rd_clr) r_rd_data <= '0;
    else if (i_rd_en)  r_rd_data <= r_mem[i_rd_addr][WIDTH-1:0];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/router_fifo.sv
// Per-port router output FIFO: header-marked words, packet byte counter, registered read data.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = ROUTER_FIFO_DEPTH,
  parameter int WIDTH = ROUTER_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  count_t         r_count;
  logic           w_wr_fire;
  logic           w_rd_fire;
  logic           w_out_clr;
  logic [WIDTH:0] w_head_word;
  logic           w_unused_head;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Legality uses pre-edge flags; soft_reset suppresses both sides.
  assign w_wr_fire     = write_enb && !full && !soft_reset;
  assign w_rd_fire     = read_enb && !empty && !soft_reset;
  assign w_out_clr     = soft_reset || (!w_rd_fire && (r_count == '0));
  assign w_unused_head = ^w_head_word[HDR_LEN_LSB-1:0];

  router_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_fire),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data ({lfd_state, data_in}),
    .i_rd_en   (w_rd_fire),
    .i_rd_clr  (w_out_clr),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_peek    (w_head_word),
    .o_rd_data (data_out)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (soft_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        if (w_head_word[WIDTH])
          r_count <= hdr_to_count(w_head_word[HDR_LEN_MSB:HDR_LEN_LSB]);
        else if (r_count != '0)
          r_count <= r_count - count_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: queue-based reference model, directed and random traffic.
module tb_router_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  router_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] dout;
    logic       full;
    logic       empty;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [8:0] mq[$];
  int         m_count = 0;
  logic [7:0] m_dout = 8'h00;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {marker, byte}; outputs predicted for the cycle after the edge.
  task automatic cycle(input bit we, input bit re, input bit lfd, input bit srst,
                       input logic [7:0] din, input string tag);
    exp_t       e;
    bit         was_full, was_empty;
    logic [8:0] w;
    @(negedge clk);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    soft_reset = srst;
    data_in    = din;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (srst) begin
      mq.delete();
      m_count = 0;
      m_dout  = 8'h00;
    end else begin
      if (re && !was_empty) begin
        w = mq.pop_front();
        m_dout = w[7:0];
        if (w[8]) m_count = (int'(w[7:2]) + 1) % 64;
        else if (m_count > 0) m_count--;
      end else if (m_count == 0) begin
        m_dout = 8'h00;
      end
      if (we && !was_full) mq.push_back({lfd, din});
    end
    e.tag   = tag;
    e.dout  = m_dout;
    e.full  = (mq.size() == DEPTH);
    e.empty = (mq.size() == 0);
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [7:0] d, input bit lfd, input string tag);
    cycle(1'b1, 1'b0, lfd, 1'b0, d, tag);
  endtask

  task automatic rd(input string tag);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, tag);
  endtask

  // Monitor: compares every cycle for which a prediction is pending.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.tag, " data_out"}, 32'(data_out), 32'(mon_e.dout));
      check({mon_e.tag, " full"}, 32'(full), 32'(mon_e.full));
      check({mon_e.tag, " empty"}, 32'(empty), 32'(mon_e.empty));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t expected < 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pkt [5];
    pkt = '{8'h0D, 8'h07, 8'h08, 8'h01, 8'h02};

    #2 rst = 1'b0;
    #1;
    check("reset empty", 32'(empty), 32'd1);
    check("reset full", 32'(full), 32'd0);
    check("reset data_out", 32'(data_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Packet pass-through, back-to-back reads.
    for (int i = 0; i < 5; i++) wr(pkt[i], i == 0, "pkt wr");
    for (int i = 0; i < 5; i++) rd("pkt rd");
    idle("pkt idle");
    idle("pkt idle2");

    // Same packet with gaps: data_out holds while bytes remain, clears after parity.
    for (int i = 0; i < 5; i++) wr(pkt[i], i == 0, "gap wr");
    for (int i = 0; i < 5; i++) begin
      rd("gap rd");
      idle("gap hold");
    end
    idle("gap idle");

    // Full boundary, drop at full, same-cycle read+write at full.
    for (int i = 0; i < 17; i++) wr(8'(i), 1'b0, "full wr");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h77, "full rw");
    for (int i = 0; i < 15; i++) rd("full drain");
    idle("full idle");

    // Wrap-around of both pointers.
    for (int i = 0; i < 10; i++) wr(8'($urandom), 1'b0, "wrap wr1");
    for (int i = 0; i < 10; i++) rd("wrap rd1");
    for (int i = 0; i < 10; i++) wr(8'hA0 + 8'(i), 1'b0, "wrap wr2");
    for (int i = 0; i < 10; i++) rd("wrap rd2");
    idle("wrap idle");

    // Read while empty together with a write.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, "empty rw");
    rd("empty rd");
    idle("empty idle");

    // Soft reset mid-packet overrides a concurrent write.
    wr(8'h0D, 1'b1, "srst wr");
    wr(8'h11, 1'b0, "srst wr");
    wr(8'h22, 1'b0, "srst wr");
    rd("srst rd");
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h99, "srst");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "srst rd empty");
    idle("srst idle");

    // Asynchronous reset with three words stored.
    wr(8'h31, 1'b1, "arst wr");
    wr(8'h32, 1'b0, "arst wr");
    wr(8'h33, 1'b0, "arst wr");
    rd("arst rd");
    @(negedge clk);
    write_enb = 1'b0;
    read_enb  = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst empty", 32'(empty), 32'd1);
    check("arst full", 32'(full), 32'd0);
    check("arst data_out", 32'(data_out), 32'd0);
    mq.delete();
    m_count = 0;
    m_dout  = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    wr(8'h44, 1'b0, "post arst wr");
    rd("post arst rd");
    idle("post arst idle");

    // Random traffic: fill-biased phase, then drain-biased phase, rare soft resets.
    for (int i = 0; i < 400; i++) begin
      bit we, re, lfd, srst;
      if (i < 200) begin
        we = ($urandom % 4) != 0;
        re = ($urandom % 4) == 0;
      end else begin
        we = ($urandom % 4) == 0;
        re = ($urandom % 4) != 0;
      end
      lfd  = ($urandom % 6) == 0;
      srst = ($urandom % 60) == 0;
      cycle(we, re, lfd, srst, 8'($urandom), "rand");
    end
    idle("final idle");

    @(posedge clk);
    #2;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
